// File: rtl/op_ctrl_pkg.sv
// Shared definitions for the op_ctrl control unit: opcode/funct constants,
// ALU function codes, FSM state encoding and the decoded control word.
// Optional feature macro: OP_CTRL_TRAP_EN adds the TRAP state.
package op_ctrl_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // R-type funct field (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes (MIPS funct encoding)
  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_COMMIT,
    ST_HALTED
`ifdef OP_CTRL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  // Decoded control word, gated by FSM state in the top level
  typedef struct packed {
    logic       rd_mux_s;
    logic       op2_mux_s;
    logic [5:0] alu_funct;
    logic       is_write;
    logic       is_beq;
    logic       is_bne;
    logic       is_halt;
    logic       is_illegal;
  } ctrl_t;

endpackage

// File: rtl/op_ctrl_decode.sv
// Combinational instruction decoder: IR opcode/funct to control word.
module op_ctrl_decode
  import op_ctrl_pkg::*;
#(
  parameter logic [5:0] IR_HALT = 6'h3F
) (
  input  logic [5:0] ir_opcode,
  input  logic [5:0] ir_funct,
  output ctrl_t      ctrl
);

  // Map opcode/funct to selects, ALU code and instruction class flags
  always_comb begin
    ctrl = '0;
    if (ir_opcode == IR_HALT) begin
      ctrl.is_halt = 1'b1;
    end else begin
      case (ir_opcode)
        OP_RTYPE: begin
          case (ir_funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
              ctrl.rd_mux_s  = 1'b1;
              ctrl.alu_funct = ir_funct;
              ctrl.is_write  = 1'b1;
            end
            default: ctrl.is_illegal = 1'b1;
          endcase
        end
        OP_ADDI: begin
          ctrl.op2_mux_s = 1'b1;
          ctrl.alu_funct = ALU_ADD;
          ctrl.is_write  = 1'b1;
        end
        OP_ANDI: begin
          ctrl.op2_mux_s = 1'b1;
          ctrl.alu_funct = ALU_AND;
          ctrl.is_write  = 1'b1;
        end
        OP_ORI: begin
          ctrl.op2_mux_s = 1'b1;
          ctrl.alu_funct = ALU_OR;
          ctrl.is_write  = 1'b1;
        end
        OP_BEQ: begin
          ctrl.alu_funct = ALU_SUB;
          ctrl.is_beq    = 1'b1;
        end
        OP_BNE: begin
          ctrl.alu_funct = ALU_SUB;
          ctrl.is_bne    = 1'b1;
        end
        default: ctrl.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/op_ctrl.sv
// Multi-cycle control unit for the op_aut datapath: FETCH/EXEC/COMMIT
// sequencing, IR latching, retired-instruction count.
// Optional feature macro: OP_CTRL_TRAP_EN (illegal output and TRAP state).
module op_ctrl
  import op_ctrl_pkg::*;
#(
  parameter logic [5:0]  IR_HALT = 6'h3F,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             load,
  output logic             write,
  output logic             rd_mux_s,
  output logic             op2_mux_s,
  output logic [5:0]       alu_funct,
  output logic             branch_mux_s,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
`ifdef OP_CTRL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t     state_q, state_d;
  logic [5:0] ir_opcode, ir_funct;
  ctrl_t      ctrl;

  op_ctrl_decode #(.IR_HALT(IR_HALT)) u_decode (
    .ir_opcode(ir_opcode),
    .ir_funct (ir_funct),
    .ctrl     (ctrl)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Instruction register, captured at the end of FETCH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_opcode <= '0;
      ir_funct  <= '0;
    end else if (state_q == ST_FETCH) begin
      ir_opcode <= opcode;
      ir_funct  <= funct;
    end
  end

  // Retired counter: load is asserted exactly once per counted commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    retired <= '0;
    else if (load) retired <= retired + 1'b1;
  end

  // Next-state and state-gated outputs
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    write        = 1'b0;
    rd_mux_s     = 1'b0;
    op2_mux_s    = 1'b0;
    alu_funct    = '0;
    branch_mux_s = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
`ifdef OP_CTRL_TRAP_EN
    illegal      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        busy      = 1'b1;
        rd_mux_s  = ctrl.rd_mux_s;
        op2_mux_s = ctrl.op2_mux_s;
        alu_funct = ctrl.alu_funct;
        state_d   = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy         = 1'b1;
        rd_mux_s     = ctrl.rd_mux_s;
        op2_mux_s    = ctrl.op2_mux_s;
        alu_funct    = ctrl.alu_funct;
        branch_mux_s = (ctrl.is_beq & zero) | (ctrl.is_bne & ~zero);
        if (ctrl.is_halt) begin
          state_d = ST_HALTED;
`ifdef OP_CTRL_TRAP_EN
        end else if (ctrl.is_illegal) begin
          state_d = ST_TRAP;
`endif
        end else begin
          // Without trapping, unsupported encodings commit as a counted NOP
          load    = 1'b1;
          write   = ctrl.is_write & ~ctrl.is_illegal;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
`ifdef OP_CTRL_TRAP_EN
      ST_TRAP: begin
        illegal = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_op_ctrl.sv
// Self-checking bench for op_ctrl: directed steps plus randomized
// instruction stream checked against a table-driven reference model.
module tb_op_ctrl;

`ifdef OP_CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic        zero  = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct  = '0;
  logic        load, write, rd_mux_s, op2_mux_s, branch_mux_s, busy, halted;
  logic [5:0]  alu_funct;
  logic [15:0] retired;
`ifdef OP_CTRL_TRAP_EN
  logic        illegal;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_retired = '0;

  op_ctrl #(.IR_HALT(6'h3F), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .load        (load),
    .write       (write),
    .rd_mux_s    (rd_mux_s),
    .op2_mux_s   (op2_mux_s),
    .alu_funct   (alu_funct),
    .branch_mux_s(branch_mux_s),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired)
`ifdef OP_CTRL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  always #5 clock = ~clock;

  // Expected behaviour of one instruction, straight from the ISA table
  typedef struct packed {
    logic       legal;
    logic       halt;
    logic       rd;
    logic       op2;
    logic [5:0] alu;
    logic       wr;
    logic       beq;
    logic       bne;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e = '0;
    e.legal = 1'b1;
    case (op)
      6'h3F: e.halt = 1'b1;
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
          e.rd = 1'b1; e.alu = fn; e.wr = 1'b1;
        end else e.legal = 1'b0;
      end
      6'h08: begin e.op2 = 1'b1; e.alu = 6'h20; e.wr = 1'b1; end
      6'h0C: begin e.op2 = 1'b1; e.alu = 6'h24; e.wr = 1'b1; end
      6'h0D: begin e.op2 = 1'b1; e.alu = 6'h25; e.wr = 1'b1; end
      6'h04: begin e.alu = 6'h22; e.beq = 1'b1; end
      6'h05: begin e.alu = 6'h22; e.bne = 1'b1; end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {load, write, rd_mux_s, op2_mux_s, alu_funct, branch_mux_s, busy, halted};
  endfunction

  // Hold reset for a few cycles, check quiescent outputs, release after an edge
  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    #1;
    chk("rst_outs", {19'd0, outs()}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_retired", {16'd0, retired}, 32'd0);
    reset = 1'b1;
    exp_retired = '0;
  endtask

  // Entered just after the edge that starts FETCH; ends just after the edge
  // following COMMIT. nrun is the run level from FETCH onward.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic nrun);
    exp_t e;
    logic exp_load;
    e = model(op, fn);
    exp_load = !e.halt && (e.legal || !TRAP);
    chk("fetch_outs", {19'd0, outs()}, {19'd0, 13'b0_0_0_0_000000_0_1_0});
    opcode = op;
    funct  = fn;
    run    = nrun;
    @(posedge clock); #1;
    // EXEC: live inputs scrambled, decode must come from the IR
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    zero   = 1'($urandom);
    #1;
    if (e.legal && !e.halt)
      chk("exec_ctrl", {24'd0, rd_mux_s, op2_mux_s, alu_funct}, {24'd0, e.rd, e.op2, e.alu});
    chk("exec_lwb", {28'd0, load, write, branch_mux_s, busy}, 32'b0001);
    @(posedge clock); #1;
    // COMMIT
    zero = z;
    #1;
    if (e.legal && !e.halt)
      chk("commit_ctrl", {24'd0, rd_mux_s, op2_mux_s, alu_funct}, {24'd0, e.rd, e.op2, e.alu});
    chk("commit_lwbb", {12'd0, load, write, branch_mux_s, busy, retired},
        {12'd0, exp_load, e.wr, (e.beq & z) | (e.bne & ~z), 1'b1, exp_retired});
    zero = ~z;
    #1;
    chk("commit_zero_flip", {31'd0, branch_mux_s}, {31'd0, (e.beq & ~z) | (e.bne & z)});
    zero = z;
    @(posedge clock); #1;
    if (exp_load) exp_retired = exp_retired + 16'd1;
    chk("post_retired", {16'd0, retired}, {16'd0, exp_retired});
    chk("post_lw", {30'd0, load, write}, 32'd0);
    if (e.halt)
      chk("post_halt", {30'd0, halted, busy}, 32'b10);
    else if (!e.legal && TRAP) begin
`ifdef OP_CTRL_TRAP_EN
      chk("post_trap", {29'd0, illegal, halted, busy}, 32'b100);
`endif
    end else
      chk("post_busy", {31'd0, busy}, {31'd0, nrun});
  endtask

  // From IDLE with run low: raise run and step into FETCH
  task automatic start_from_idle();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    run    = 1'b1;
    @(posedge clock); #1;
  endtask

  logic [5:0] ops [8];
  logic [5:0] rfn [5];

  initial begin
    logic [5:0] op, fn;
    logic       nrun;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05};
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    // Reset, then 10 idle cycles with run low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("idle_outs", {3'd0, outs(), retired}, 32'd0);
    end

    // Directed: add, then beq/bne with both zero values, run held high
    start_from_idle();
    do_instr(6'h00, 6'h20, 1'b0, 1'b1);
    chk("add_retired_one", {16'd0, retired}, 32'd1);
    do_instr(6'h04, 6'($urandom), 1'b1, 1'b1);
    do_instr(6'h04, 6'($urandom), 1'b0, 1'b1);
    do_instr(6'h05, 6'($urandom), 1'b1, 1'b1);
    do_instr(6'h05, 6'($urandom), 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clock); #1;
      chk("idle_after_drop", {31'd0, busy}, 32'd0);
    end

    // Randomized stream with random run drops
    start_from_idle();
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 7)];
      fn = (op == 6'h00) ? rfn[$urandom_range(0, 4)] : 6'($urandom);
      if (!TRAP && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin op = 6'h00; fn = 6'h21; end
        else begin op = 6'h2B; fn = 6'($urandom); end
      end
      nrun = ($urandom_range(0, 3) != 0);
      do_instr(op, fn, 1'($urandom), nrun);
      if (!nrun) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock); #1;
          chk("rand_idle", {31'd0, busy}, 32'd0);
        end
        start_from_idle();
      end
    end

    // Reset asserted during EXEC of an addi: no partial commit
    run = 1'b0;
    @(posedge clock); #1;
    do_reset();
    start_from_idle();
    opcode = 6'h08;
    funct  = 6'($urandom);
    @(posedge clock); #1;
    chk("addi_exec_op2", {31'd0, op2_mux_s}, 32'd1);
    #2;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    chk("rst_exec_outs", {3'd0, outs(), retired}, 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
      chk("rst_hold_lw", {14'd0, load, write, retired}, 32'd0);
    end
    reset = 1'b1;
    exp_retired = '0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("rst_release_idle", {3'd0, outs(), retired}, 32'd0);
    end

    // Unsupported opcode 0x2B
    start_from_idle();
    do_instr(6'h2B, 6'($urandom), 1'($urandom), 1'b1);
`ifdef OP_CTRL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("trap_sticky", {12'd0, illegal, busy, load, write, retired}, 32'h80000);
    end
    do_reset();
    start_from_idle();
`endif

    // HALT: no load, halted sticky with run high
    do_instr(6'h3F, 6'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("halt_sticky", {12'd0, halted, busy, load, write, retired},
          {12'd0, 4'b1000, exp_retired});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_ctrl.md
# op_ctrl

Multi-cycle control unit that sequences the single-cycle MIPS-subset operative datapath (`op_aut`). Each instruction takes three cycles: FETCH, EXEC, COMMIT. The block latches `opcode`/`funct` from the datapath and drives its control inputs: mux selects, ALU function, PC load and register-file write. PC and register file are therefore updated only once, in COMMIT, after the ALU result and `zero` have settled.

## Interface
- `IR_HALT`, 6'h3F, opcode that stops execution.
- `CNT_W`, 16, width of retired-instruction counter.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level enable; instructions issue while high.
- `opcode`  in  6  `instruction[31:26]` from datapath.
- `funct`  in  6  `instruction[5:0]` from datapath.
- `zero`  in  1  ALU zero flag from datapath.
- `load`  out  1  PC register load.
- `write`  out  1  register-file write enable.
- `rd_mux_s`  out  1  destination select: 0 = rt, 1 = rd.
- `op2_mux_s`  out  1  ALU operand 2 select: 0 = rdata2, 1 = sign-extended immediate.
- `alu_funct`  out  6  ALU operation code (MIPS funct encoding).
- `branch_mux_s`  out  1  next-PC select: 0 = PC+4, 1 = branch target.
- `busy`  out  1  high in FETCH/EXEC/COMMIT.
- `halted`  out  1  sticky; HALT opcode was committed.
- `retired`  out  CNT_W  count of committed instructions.

## Operation
- Supported instructions:
  - R-type (op 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - addi 0x08, andi 0x0C, ori 0x0D.
  - beq 0x04, bne 0x05.
  - `IR_HALT`.
- States and transitions:
  - IDLE: `run`=1 → FETCH.
  - FETCH: latch `opcode`/`funct` into IR registers → EXEC.
  - EXEC → COMMIT.
  - COMMIT: `run`=1 → FETCH, else → IDLE. A committed HALT goes → HALTED.
  - HALTED: stays until reset.
- Decode is taken from the IR registers, never from the live `opcode`/`funct` inputs.
  - R-type: `rd_mux_s`=1, `op2_mux_s`=0, `alu_funct`=funct.
  - addi/andi/ori: `rd_mux_s`=0, `op2_mux_s`=1, `alu_funct` = 0x20 / 0x24 / 0x25.
  - beq/bne: `op2_mux_s`=0, `alu_funct`=0x22.
- Selects and `alu_funct` are driven in EXEC and COMMIT. They are 0 in every other state.
- COMMIT outputs:
  - `load`=1 for every instruction except HALT.
  - `write`=1 for R-type, addi, andi and ori only.
  - `branch_mux_s` = (beq & `zero`) | (bne & ~`zero`).
  - These are the only outputs that depend combinationally on `zero`.
- `retired` increments by 1 on each non-HALT COMMIT and wraps from all-ones to 0.
- Unsupported opcode or R-type funct, with `OP_CTRL_TRAP_EN` undefined: executes as a NOP (COMMIT with `load`=1, `write`=0) and is counted in `retired`.
- A `run` drop during FETCH or EXEC does not abort the instruction. It completes, then the FSM goes to IDLE.

## Timing
- Reset (asynchronous): state → IDLE, IR → 0, `retired` → 0, `halted` → 0. All outputs are 0 during and after reset.
- Reset asserted mid-instruction drops `load`/`write` immediately, with no partial commit.
- Issue latency: `run` sampled high in IDLE at edge N → FETCH in cycle N+1, EXEC in N+2, COMMIT in N+3. PC and register file update at the end of N+3.
- Sustained throughput with `run` held high: one instruction per 3 cycles.
- `load` and `write` are high for exactly one cycle per instruction.

## Configuration
- `OP_CTRL_TRAP_EN` defined:
  - Adds output `illegal` (1 bit, reset 0).
  - An unsupported opcode or funct in COMMIT asserts no `load` and no `write`, does not increment `retired`, sets `illegal`=1 and enters state TRAP.
  - TRAP is sticky until reset; `busy`=0 in TRAP.
- `OP_CTRL_TRAP_EN` undefined: the port and state are absent, and the NOP behaviour above applies.

## Structure
- Shared package `op_ctrl_pkg` holds:
  - opcode constants;
  - funct constants;
  - ALU function codes;
  - state encoding (IDLE, FETCH, EXEC, COMMIT, HALTED, TRAP).
- One sub-module, `op_ctrl_decode`: combinational, from IR opcode/funct to the control word (`rd_mux_s`, `op2_mux_s`, `alu_funct`, `is_write`, `is_beq`, `is_bne`, `is_halt`, `is_illegal`). The FSM gates this control word by state.

## Test plan
- Reset low then high, `run`=0 → all outputs 0, `retired`=0, FSM holds IDLE for 10 cycles.
- `run`=1, opcode 0x00 funct 0x20 → `rd_mux_s`=1, `alu_funct`=0x20 in EXEC; `load`=`write`=1 exactly in cycle 3; `retired`=1.
- opcode 0x04 with `zero`=1 → `branch_mux_s`=1 and `load`=1 in COMMIT, `write`=0. Repeat with `zero`=0 → `branch_mux_s`=0. Repeat with opcode 0x05 → inverse results.
- opcode 0x3F → no `load`; `halted`=1 from the next cycle; FSM stays HALTED with `run`=1 for 20 cycles.
- Reset pulled low during EXEC of an addi → `load`/`write` stay 0, `retired` unchanged at 0, IDLE after release.
- opcode 0x2B with `OP_CTRL_TRAP_EN` defined → `illegal`=1, no `load`, `retired` unchanged. With the macro undefined → `load`=1, `write`=0, `retired`+1.
